// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared definitions for the SPI memory master: the frame state encoding,
// the 2-bit frame command codes and the frame length in bits.
// Optional feature macro used by the top: SPI_MEM_MASTER_ADDR_CACHE_EN.
// -----------------------------------------------------------------------------
package spi_mem_pkg;

  localparam int FRAME_BITS = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } frame_state_e;

endpackage

// File: rtl/spi_mem_master_if.sv
// -----------------------------------------------------------------------------
// spi_mem_master_if
// Host-side bus of the SPI memory master.
//   req_valid/req_ready : request handshake. A request transfers on a rising
//                         edge where both are high; req_rd/req_addr/req_wdata
//                         must be stable while req_valid is high. req_valid
//                         seen while req_ready is low is ignored (not queued).
//   rd_valid/rd_data    : one-cycle pulse when a read byte has arrived;
//                         rd_data holds until the next read completes.
//   dbg_state/dbg_seq   : frame FSM state and sequencer bit (observation only).
// Modports: master = host side, slave = spi_mem_master side.
// -----------------------------------------------------------------------------
interface spi_mem_master_if;
  import spi_mem_pkg::*;

  logic         req_valid;
  logic         req_ready;
  logic         req_rd;
  logic [7:0]   req_addr;
  logic [7:0]   req_wdata;
  logic         rd_valid;
  logic [7:0]   rd_data;
  frame_state_e dbg_state;
  logic         dbg_seq;

  modport master (
    output req_valid, req_rd, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data, dbg_state, dbg_seq
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data, dbg_state, dbg_seq
  );

endinterface

// File: rtl/spi_mem_frame.sv
// -----------------------------------------------------------------------------
// spi_mem_frame
// Runs one SPI frame: SEL (1 cycle) -> SHIFT (10 bits {cmd,payload}, MSB
// first) -> [WAIT (RD_WAIT cycles) -> RECV (8 MISO samples)] -> GAP (GAP
// cycles, SS_n high). WAIT/RECV are entered only for the RD_DATA command.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : start a frame; taken in IDLE or on the last GAP cycle
//   i_cmd/i_payload : frame contents, captured with i_start
//   i_miso          : serial input from the slave
//   o_done          : high during the last GAP cycle of a frame
//   o_mosi, o_ss_n  : registered serial outputs
//   o_rd_valid      : one-cycle pulse after the 8th MISO sample
//   o_rd_data       : received byte, held until the next reception
//   o_state         : current FSM state
// -----------------------------------------------------------------------------
module spi_mem_frame
  import spi_mem_pkg::*;
#(
  parameter int RD_WAIT = 1,
  parameter int GAP     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [1:0]   i_cmd,
  input  logic [7:0]   i_payload,
  input  logic         i_miso,
  output logic         o_done,
  output logic         o_mosi,
  output logic         o_ss_n,
  output logic         o_rd_valid,
  output logic [7:0]   o_rd_data,
  output frame_state_e o_state
);

  frame_state_e          r_state;
  logic [3:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_sh;
  logic [6:0]            r_rx;
  logic                  r_mosi;
  logic                  r_ss_n;
  logic                  r_rd_valid;
  logic [7:0]            r_rd_data;
  logic                  r_recv;
  logic                  w_done;
  logic                  w_load;

  assign w_done = (r_state == ST_GAP) && (r_cnt == 4'(GAP - 1));
  // A new frame may follow directly on the last GAP cycle, so back-to-back
  // frames have no idle cycle between them.
  assign w_load = i_start && ((r_state == ST_IDLE) || w_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_sh       <= '0;
      r_rx       <= 7'd0;
      r_mosi     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_recv     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_load) begin
        // SEL already presents the first command bit on MOSI.
        r_state <= ST_SEL;
        r_cnt   <= 4'd0;
        r_sh    <= {i_cmd, i_payload};
        r_mosi  <= i_cmd[1];
        r_ss_n  <= 1'b0;
        r_recv  <= (i_cmd == CMD_RD_DATA);
      end else begin
        unique case (r_state)
          ST_IDLE: ;
          ST_SEL: begin
            r_state <= ST_SHIFT;
            r_cnt   <= 4'd0;
            r_mosi  <= r_sh[FRAME_BITS-1];
            r_sh    <= {r_sh[FRAME_BITS-2:0], 1'b0};
          end
          ST_SHIFT: begin
            if (r_cnt == 4'(FRAME_BITS - 1)) begin
              r_cnt  <= 4'd0;
              r_mosi <= 1'b0;
              if (!r_recv) begin
                r_state <= ST_GAP;
                r_ss_n  <= 1'b1;
              end else if (RD_WAIT == 0) begin
                r_state <= ST_RECV;
              end else begin
                r_state <= ST_WAIT;
              end
            end else begin
              r_cnt  <= r_cnt + 4'd1;
              r_mosi <= r_sh[FRAME_BITS-1];
              r_sh   <= {r_sh[FRAME_BITS-2:0], 1'b0};
            end
          end
          ST_WAIT: begin
            if (r_cnt == 4'(RD_WAIT - 1)) begin
              r_state <= ST_RECV;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          ST_RECV: begin
            r_rx <= {r_rx[5:0], i_miso};
            if (r_cnt == 4'd7) begin
              r_rd_data  <= {r_rx, i_miso};
              r_rd_valid <= 1'b1;
              r_state    <= ST_GAP;
              r_ss_n     <= 1'b1;
              r_cnt      <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          ST_GAP: begin
            if (w_done) begin
              r_state <= ST_IDLE;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign o_done     = w_done;
  assign o_mosi     = r_mosi;
  assign o_ss_n     = r_ss_n;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_state    = r_state;

endmodule

// File: rtl/spi_mem_master.sv
// -----------------------------------------------------------------------------
// spi_mem_master
// Turns host read/write requests into two SPI frames: an address frame
// (WR_ADDR / RD_ADDR) followed by a data frame (WR_DATA / RD_DATA).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : spi_mem_master_if.slave host interface
//   MOSI     : serial data to slave (registered)
//   MISO     : serial data from slave
//   SS_n     : slave select, active-low (registered)
// Parameters: RD_WAIT (0..15), GAP (1..15).
// Optional feature: define SPI_MEM_MASTER_ADDR_CACHE_EN to remember the last
// written and last read address; a request hitting the cache of its own kind
// skips the address frame.
// -----------------------------------------------------------------------------
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int RD_WAIT = 1,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_mem_master_if.slave  bus,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SS_n
);

  logic       r_ready;
  logic       r_seq;     // 0: first frame of the request, 1: data frame
  logic       r_rd;
  logic [7:0] r_wdata;

  logic       w_accept;
  logic       w_hit;
  logic       w_start;
  logic       w_done;
  logic [1:0] w_cmd;
  logic [7:0] w_payload;

  assign w_accept = bus.req_valid && r_ready;

`ifdef SPI_MEM_MASTER_ADDR_CACHE_EN
  logic       r_wc_valid;
  logic [7:0] r_wc_addr;
  logic       r_rc_valid;
  logic [7:0] r_rc_addr;
  logic [7:0] r_addr;

  assign w_hit = bus.req_rd ? (r_rc_valid && (r_rc_addr == bus.req_addr))
                            : (r_wc_valid && (r_wc_addr == bus.req_addr));

  // An entry is refreshed only once its address frame has fully gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wc_valid <= 1'b0;
      r_wc_addr  <= 8'h00;
      r_rc_valid <= 1'b0;
      r_rc_addr  <= 8'h00;
      r_addr     <= 8'h00;
    end else begin
      if (w_accept) begin
        r_addr <= bus.req_addr;
      end else if (!r_ready && !r_seq && w_done) begin
        if (r_rd) begin
          r_rc_valid <= 1'b1;
          r_rc_addr  <= r_addr;
        end else begin
          r_wc_valid <= 1'b1;
          r_wc_addr  <= r_addr;
        end
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // The first frame starts on the acceptance edge straight from the bus;
  // the data frame starts on the last GAP cycle of the address frame.
  always_comb begin
    w_start   = 1'b0;
    w_cmd     = CMD_WR_ADDR;
    w_payload = 8'h00;
    if (w_accept) begin
      w_start = 1'b1;
      if (w_hit) begin
        w_cmd     = bus.req_rd ? CMD_RD_DATA : CMD_WR_DATA;
        w_payload = bus.req_rd ? 8'h00 : bus.req_wdata;
      end else begin
        w_cmd     = bus.req_rd ? CMD_RD_ADDR : CMD_WR_ADDR;
        w_payload = bus.req_addr;
      end
    end else if (!r_ready && !r_seq && w_done) begin
      w_start   = 1'b1;
      w_cmd     = r_rd ? CMD_RD_DATA : CMD_WR_DATA;
      w_payload = r_rd ? 8'h00 : r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_seq   <= 1'b0;
      r_rd    <= 1'b0;
      r_wdata <= 8'h00;
    end else if (w_accept) begin
      r_ready <= 1'b0;
      r_seq   <= w_hit;
      r_rd    <= bus.req_rd;
      r_wdata <= bus.req_wdata;
    end else if (!r_ready && w_done) begin
      if (!r_seq) begin
        r_seq <= 1'b1;
      end else begin
        r_seq   <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  spi_mem_frame #(
    .RD_WAIT (RD_WAIT),
    .GAP     (GAP)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_cmd      (w_cmd),
    .i_payload  (w_payload),
    .i_miso     (MISO),
    .o_done     (w_done),
    .o_mosi     (MOSI),
    .o_ss_n     (SS_n),
    .o_rd_valid (bus.rd_valid),
    .o_rd_data  (bus.rd_data),
    .o_state    (bus.dbg_state)
  );

  assign bus.req_ready = r_ready;
  assign bus.dbg_seq   = r_seq;

endmodule

// File: tb/tb_spi_mem_master.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_master
// Self-checking bench for spi_mem_master. A behavioural SPI slave decodes
// every frame, compares it against an expected-frame queue and serves reads
// from a small memory. Define SPI_MEM_MASTER_ADDR_CACHE_EN to check the
// address-cache build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_mem_master;
  import spi_mem_pkg::*;

  localparam int RD_WAIT   = 1;
  localparam int GAP       = 1;
  localparam int FRAME_CYC = 11 + GAP;
  localparam int WR_LAT    = 2 * FRAME_CYC;
  localparam int RD_LAT    = 2 * FRAME_CYC + RD_WAIT + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi;
  logic ss_n;
  logic miso = 1'b0;

  always #5 clk = ~clk;

  spi_mem_master_if bus ();

  spi_mem_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .MOSI (mosi),
    .MISO (miso),
    .SS_n (ss_n)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- SPI slave model ----------------
  int         low_cnt = 0;
  logic [9:0] sl_sh   = 10'd0;
  logic [7:0] sl_wa   = 8'h00;
  logic [7:0] sl_ra   = 8'h00;
  logic [7:0] sl_byte = 8'h00;
  logic [7:0] sl_mem [256];

  always @(negedge clk) begin
    if (ss_n) begin
      low_cnt = 0;
      miso    = 1'b0;
    end else begin
      low_cnt++;
      if (low_cnt >= 2 && low_cnt <= 11) sl_sh = {sl_sh[8:0], mosi};
      if (low_cnt == 11) begin
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("frame_bits", 32'(sl_sh), 32'(exp_q.pop_front()));
        case (sl_sh[9:8])
          2'b00: sl_wa = sl_sh[7:0];
          2'b01: sl_mem[sl_wa] = sl_sh[7:0];
          2'b10: sl_ra = sl_sh[7:0];
          default: sl_byte = sl_mem[sl_ra];
        endcase
      end
      if (low_cnt >= 12 + RD_WAIT && low_cnt <= 19 + RD_WAIT)
        miso = sl_byte[7 - (low_cnt - 12 - RD_WAIT)];
      else
        miso = 1'b0;
    end
  end

  // ---------------- expected-frame model ----------------
  bit         m_wc_v = 1'b0;
  bit         m_rc_v = 1'b0;
  logic [7:0] m_wc_a = 8'h00;
  logic [7:0] m_rc_a = 8'h00;

  function automatic bit predict(input bit rd, input logic [7:0] a, input logic [7:0] wd);
    bit hit;
    hit = 1'b0;
`ifdef SPI_MEM_MASTER_ADDR_CACHE_EN
    hit = rd ? (m_rc_v && m_rc_a == a) : (m_wc_v && m_wc_a == a);
`endif
    if (!hit) exp_q.push_back(rd ? {CMD_RD_ADDR, a} : {CMD_WR_ADDR, a});
    exp_q.push_back(rd ? {CMD_RD_DATA, 8'h00} : {CMD_WR_DATA, wd});
    if (rd) begin m_rc_v = 1'b1; m_rc_a = a; end
    else    begin m_wc_v = 1'b1; m_wc_a = a; end
    return hit;
  endfunction

  // ---------------- driver ----------------
  task automatic wait_ready();
    int guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
  endtask

  task automatic do_req(input string name, input bit rd, input logic [7:0] a, input logic [7:0] wd,
                        input bit hold, output int lat, output logic [7:0] got);
    bit hit;
    int pulses;
    hit = predict(rd, a, wd);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_rd = rd; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0; pulses = 0;
    while (bus.req_ready !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (bus.rd_valid === 1'b1) pulses++;
    end
    bus.req_valid = 1'b0;
    got = bus.rd_data;
    check({name, "_latency"}, 32'(lat), 32'((rd ? RD_LAT : WR_LAT) - (hit ? FRAME_CYC : 0)));
    check({name, "_rd_pulses"}, 32'(pulses), rd ? 32'd1 : 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;   // read result, or held rd_data for writes
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat, lat1, lat2, lows, gap_hi, gap_mosi;
    logic [7:0] got, wd;
    logic [10:0] w1, w2;

    for (int i = 0; i < 256; i++) sl_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;

    vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'h0B};
    vecs[1] = '{1'b0, 8'hFF, 8'h5A, 8'h0B};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h5A};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 8'h37, 8'h00, 8'hA5};
    vecs[5] = '{1'b1, 8'h37, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 8'h37, 8'hFF, 8'h00};
    vecs[7] = '{1'b1, 8'h37, 8'h00, 8'hFF};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'h00);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    // Write 100 <- 11, MOSI/SS_n traced cycle by cycle.
    void'(predict(1'b0, 8'd100, 8'd11));
    wait_ready();
    bus.req_valid = 1'b1; bus.req_rd = 1'b0; bus.req_addr = 8'd100; bus.req_wdata = 8'd11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("ready_drops", 32'(bus.req_ready), 32'd0);
    w1 = '0; w2 = '0; lows = 0; gap_hi = 0; gap_mosi = 0;
    for (int j = 0; j < WR_LAT; j++) begin
      if (!ss_n) lows++;
      if (j <= 10) w1 = {w1[9:0], mosi};
      else if (j >= FRAME_CYC && j <= FRAME_CYC + 10) w2 = {w2[9:0], mosi};
      else begin
        if (ss_n) gap_hi++;
        if (mosi) gap_mosi++;
      end
      @(posedge clk); #1;
    end
    check("wr_frame1_mosi", 32'(w1), 32'(11'b000_0110_0100));
    check("wr_frame2_mosi", 32'(w2), 32'(11'b001_0000_1011));
    check("wr_ss_low_cycles", 32'(lows), 32'd22);
    check("wr_gap_ss_high", 32'(gap_hi), 32'(2 * GAP));
    check("wr_gap_mosi_zero", 32'(gap_mosi), 32'd0);
    check("wr_ready_back", 32'(bus.req_ready), 32'd1);

    // Read 100 -> 11.
    do_req("rd100", 1'b1, 8'd100, 8'h00, 1'b0, lat, got);
    check("rd100_data", 32'(got), 32'd11);

    // Table of directed transactions.
    for (int i = 0; i < 8; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0, lat, got);
      check($sformatf("vec%0d_rd_data", i), 32'(got), 32'(vecs[i].exp_rd));
    end

    // req_valid held high for the whole busy period.
    do_req("hold", 1'b1, 8'hFF, 8'h00, 1'b1, lat, got);
    check("hold_rd_data", 32'(got), 32'h5A);
    repeat (FRAME_CYC + 4) @(posedge clk);
    #1;
    check("hold_no_extra_frame", 32'(exp_q.size()), 32'd0);
    check("hold_ss_idle", 32'(ss_n), 32'd1);

    // Two back-to-back reads of the same address.
    do_req("c_wr", 1'b0, 8'd50, 8'h3C, 1'b0, lat, got);
    do_req("c_rd1", 1'b1, 8'd50, 8'h00, 1'b0, lat1, got);
    check("c_rd1_data", 32'(got), 32'h3C);
    do_req("c_rd2", 1'b1, 8'd50, 8'h00, 1'b0, lat2, got);
    check("c_rd2_data", 32'(got), 32'h3C);
`ifdef SPI_MEM_MASTER_ADDR_CACHE_EN
    check("cache_saving", 32'(lat1 - lat2), 32'(FRAME_CYC));
`else
    check("no_cache_saving", 32'(lat1 - lat2), 32'd0);
`endif

    // 100 writes then 100 reads.
    for (int i = 0; i < 100; i++) begin
      wd = 8'(11 * ((i % 23) + 1));
      do_req("loop_wr", 1'b0, 8'(100 + i), wd, 1'b0, lat, got);
    end
    for (int i = 0; i < 100; i++) begin
      wd = 8'(11 * ((i % 23) + 1));
      do_req("loop_rd", 1'b1, 8'(100 + i), 8'h00, 1'b0, lat, got);
      check($sformatf("loop_rd_data_%0d", i), 32'(got), 32'(wd));
    end

    // Reset during bit 5 of the WR_DATA shift.
    void'(predict(1'b0, 8'h10, 8'h99));
    wait_ready();
    bus.req_valid = 1'b1; bus.req_rd = 1'b0; bus.req_addr = 8'h10; bus.req_wdata = 8'h99;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (17 + GAP) @(posedge clk);
    #1;
    check("abort_pre_state", 32'(bus.dbg_state), 32'(ST_SHIFT));
    check("abort_pre_seq", 32'(bus.dbg_seq), 32'd1);
    check("abort_pre_mosi_bit5", 32'(mosi), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ss_n", 32'(ss_n), 32'd1);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_wc_v = 1'b0; m_rc_v = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("abort_rd_valid_after", 32'(bus.rd_valid), 32'd0);

    // Normal operation after the abort.
    do_req("post_wr", 1'b0, 8'h10, 8'h77, 1'b0, lat, got);
    do_req("post_rd", 1'b1, 8'h10, 8'h00, 1'b0, lat, got);
    check("post_rd_data", 32'(got), 32'h77);

    repeat (4) @(posedge clk);
    #1;
    check("frames_all_seen", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
